// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the EX-stage multiply/divide unit.
// Holds the M-extension operation encodings, FSM states and operand-signedness helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } muldiv_state_e;

    function automatic logic a_is_signed(input logic [2:0] code);
        return (code == OP_MUL) || (code == OP_MULH) || (code == OP_MULHSU) ||
               (code == OP_DIV) || (code == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] code);
        return (code == OP_MUL) || (code == OP_MULH) ||
               (code == OP_DIV) || (code == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Handshake between the EX stage and the multiply/divide unit.
// The pipeline side drives operands and control; the unit answers with stall/done/result.
interface ex_muldiv_unit_if #(parameter int XLEN = riscv_pkg::XLEN);

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, done, result
    );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on a shared accumulator,
// operands latched as magnitudes and the sign re-applied on the final iteration.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   mag_b;
    logic              neg_res;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              sp_hit;
    logic [XLEN-1:0]   sp_val;
    logic              neg_in;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_sub;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     rem_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   final_val;
    logic              last_iter;

    // Acceptance-time decode: operand magnitudes, result sign and the two
    // division corner cases that bypass the iterative datapath.
    always_comb begin
        sa     = a_is_signed(bus.funct3) & bus.op_a[XLEN-1];
        sb     = b_is_signed(bus.funct3) & bus.op_b[XLEN-1];
        abs_a  = sa ? -bus.op_a : bus.op_a;
        abs_b  = sb ? -bus.op_b : bus.op_b;
        neg_in = bus.funct3[2] & bus.funct3[1] ? sa : (sa ^ sb);
        sp_hit = 1'b0;
        sp_val = '0;
        if (bus.funct3[2]) begin
            if (bus.op_b == '0) begin
                sp_hit = 1'b1;
                sp_val = bus.funct3[1] ? bus.op_a : '1;
            end else if (!bus.funct3[0] && bus.op_a == {1'b1, {(XLEN-1){1'b0}}} &&
                         bus.op_b == '1) begin
                sp_hit = 1'b1;
                sp_val = bus.funct3[1] ? '0 : bus.op_a;
            end
        end
    end

    // One iteration of either datapath. Multiply adds into the upper half and
    // shifts right; divide shifts the dividend out of the lower half into rem.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_b : {XLEN{1'b0}})};
        div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
        div_ge    = rem[XLEN] | (div_shift >= {1'b0, mag_b});
        div_sub   = div_shift - {1'b0, mag_b};
        acc_next  = acc;
        rem_next  = rem;
        if (op_q[2]) begin
            acc_next = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ge};
            rem_next = div_ge ? div_sub : div_shift;
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix  = neg_res ? -acc_next : acc_next;
        div_val   = op_q[1] ? rem_next[XLEN-1:0] : acc_next[XLEN-1:0];
        if (op_q[2]) begin
            final_val = neg_res ? -div_val : div_val;
        end else if (op_q == OP_MUL) begin
            final_val = prod_fix[XLEN-1:0];
        end else begin
            final_val = prod_fix[2*XLEN-1:XLEN];
        end
        last_iter = (cnt == CNT_W'(XLEN-1));
    end

    // Control FSM; flush beats everything except reset and never produces done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            mag_b    <= '0;
            neg_res  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q    <= muldiv_op_e'(bus.funct3);
                        mag_b   <= abs_b;
                        neg_res <= neg_in;
                        cnt     <= '0;
                        acc     <= {{XLEN{1'b0}}, abs_a};
                        rem     <= '0;
                        if (sp_hit) begin
                            result_q <= sp_val;
                            done_q   <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        result_q <= final_val;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stall  = ~bus.flush & (((state == ST_IDLE) & bus.start) | (state == ST_CALC));
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected results are queued at issue time and
// a negedge monitor compares them against every done pulse.
module tb_ex_muldiv_unit;

    logic clk;
    logic rst;
    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastResult = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the RV32M definition using wide arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        logic [63:0]     p;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expectedLatency(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected done: result %h with empty queue at %0t",
                         bus.result, $time);
            end else begin
                checkOutput("result", bus.result, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input bit toggle);
        int lat;
        int stallCnt;
        int expLat;
        expLat = expectedLatency(f, a, b);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        expQ.push_back(exp);
        lastResult = exp;
        @(negedge clk);
        stallCnt = bus.stall ? 1 : 0;
        lat      = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (toggle) begin
            bus.op_a = $urandom;
            bus.op_b = $urandom;
        end
        do begin
            @(negedge clk);
            lat++;
            if (bus.stall) stallCnt++;
            if (toggle && !bus.done) begin
                bus.start  = (lat < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
                bus.funct3 = 3'($urandom);
            end
        end while (!bus.done && lat < 100);
        bus.start = 1'b0;
        checkOutput("done latency", 32'(lat), 32'(expLat));
        checkOutput("stall cycles", 32'(stallCnt), 32'(expLat));
    endtask

    task automatic issueOnly(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'h0;
        bus.op_b   = 32'h0;
        bus.flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset done", 32'(bus.done), 32'h0);
        checkOutput("reset result", bus.result, 32'h0);
        checkOutput("reset stall", 32'(bus.stall), 32'h0);

        $display("[TB] directed operations");
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        applyStimulus(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        applyStimulus(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        $display("[TB] flush during CALC");
        issueOnly(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("stall forced low by flush", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush done", 32'(bus.done), 32'h0);
        checkOutput("flush stall", 32'(bus.stall), 32'h0);
        checkOutput("flush result held", bus.result, lastResult);
        @(posedge clk);
        applyStimulus(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D,
                      refModel(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D), 1'b0);

        $display("[TB] reset during CALC");
        issueOnly(3'd5, 32'hFFFF_0000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-op reset done", 32'(bus.done), 32'h0);
        checkOutput("mid-op reset result", bus.result, 32'h0);
        @(posedge clk); #1;
        rst        = 1'b0;
        lastResult = 32'h0;

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            applyStimulus(f, a, b, refModel(f, a, b), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
